// File: rtl/stereo_pkg.sv
// Shared FSM state type, width helpers and popcount for the census stereo
// disparity engine and its cost lane.
package stereo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  localparam int POP_MAX_W = 256;

  function automatic int disp_width(input int disp_max);
    return (disp_max < 32'sd1) ? 32'sd1 : $clog2(disp_max + 32'sd1);
  endfunction

  function automatic int cost_width(input int census_w);
    return (census_w < 32'sd1) ? 32'sd1 : $clog2(census_w + 32'sd1);
  endfunction

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] vec);
    int unsigned cnt;
    cnt = 32'd0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + {31'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/census_cost_lane.sv
// Hamming cost of one left census descriptor against LANES right descriptors,
// one registered cost per lane.
module census_cost_lane
  import stereo_pkg::*;
#(
  parameter int CENSUS_W = 45,
  parameter int LANES    = 5,
  parameter int COST_W   = 6
) (
  input  logic                             rclk,
  input  logic                             reset,
  input  logic [CENSUS_W-1:0]              left,
  input  logic [LANES-1:0][CENSUS_W-1:0]   right,
  output logic [LANES-1:0][COST_W-1:0]     cost
);

  // Register the popcount of each left/right difference
  always_ff @(posedge rclk) begin
    if (reset) begin
      cost <= '0;
    end else begin
      for (int l = 0; l < LANES; l++) begin
        cost[l] <= COST_W'(popcount(POP_MAX_W'(left ^ right[l])));
      end
    end
  end

endmodule

// File: rtl/census_disparity_engine.sv
// Census-transform disparity search over ping-pong line banks.
// Optional macro CENSUS_FALLBACK_EN: low-confidence pixels repeat the line's last confident disparity.
module census_disparity_engine
  import stereo_pkg::*;
#(
  parameter int LINE_W      = 320,
  parameter int CENSUS_W    = 45,
  parameter int DISP_MAX    = 60,
  parameter int LANES       = 5,
  parameter int COST_THRESH = 8,
  localparam int DISP_W     = disp_width(DISP_MAX),
  localparam int COST_W     = cost_width(CENSUS_W)
) (
  input  logic                rclk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [CENSUS_W-1:0] in_left,
  input  logic [CENSUS_W-1:0] in_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [DISP_W-1:0]   out_disp,
  output logic [COST_W-1:0]   out_cost,
  output logic                out_lowconf,
  output logic                err_len
);

  localparam int NGRP   = (DISP_MAX + LANES) / LANES;
  localparam int GRP_W  = $clog2(NGRP + 1);
  localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int IDX_W  = 16;

  logic [CENSUS_W-1:0]            bank_left_r  [2][LINE_W];
  logic [CENSUS_W-1:0]            bank_right_r [2][LINE_W];
  logic [1:0]                     bank_full_r;
  logic [ADDR_W-1:0]              bank_last_r  [2];
  logic                           fill_bank_r;
  logic [ADDR_W-1:0]              fill_idx_r;
  logic                           search_bank_r;
  state_e                         state_r;
  logic [ADDR_W-1:0]              x_r;
  logic [GRP_W-1:0]               cost_grp_r;
  logic [COST_W-1:0]              best_cost_r;
  logic [DISP_W-1:0]              best_disp_r;

  logic                           beat_s;
  logic                           close_s;
  logic                           overlen_s;
  logic [GRP_W-1:0]               issue_grp_s;
  logic [IDX_W-1:0]               rd_idx_s     [LANES];
  logic [IDX_W-1:0]               cand_d_s     [LANES];
  logic [CENSUS_W-1:0]            lane_left_s;
  logic [LANES-1:0][CENSUS_W-1:0] lane_right_s;
  logic [LANES-1:0][COST_W-1:0]   lane_cost_s;
  logic [COST_W-1:0]              cand_cost_s;
  logic [DISP_W-1:0]              cand_disp_s;
  logic                           lowconf_s;
  logic [DISP_W-1:0]              emit_disp_s;
  logic                           last_px_s;

  assign in_ready  = ~bank_full_r[fill_bank_r];
  assign beat_s    = in_valid & in_ready;
  assign close_s   = beat_s & (in_last | (fill_idx_r == ADDR_W'(LINE_W - 1)));
  assign overlen_s = beat_s & ~in_last & (fill_idx_r == ADDR_W'(LINE_W - 1));
  assign last_px_s = (x_r == bank_last_r[search_bank_r]);

  // Line bank storage; contents need no reset since fullness flags gate use
  always_ff @(posedge rclk) begin
    if (beat_s) begin
      bank_left_r[fill_bank_r][fill_idx_r]  <= in_left;
      bank_right_r[fill_bank_r][fill_idx_r] <= in_right;
    end
  end

  // Read addressing: READ fetches group 0, each SEARCH cycle prefetches the next group
  always_comb begin
    issue_grp_s = GRP_W'(0);
    if (state_r == ST_SEARCH) begin
      issue_grp_s = cost_grp_r + GRP_W'(1);
    end else begin
      issue_grp_s = GRP_W'(0);
    end
    lane_left_s = bank_left_r[search_bank_r][x_r];
    for (int l = 0; l < LANES; l++) begin
      rd_idx_s[l] = IDX_W'(x_r) + IDX_W'(issue_grp_s) * IDX_W'(LANES) + IDX_W'(l);
      if (rd_idx_s[l] < IDX_W'(LINE_W)) begin
        lane_right_s[l] = bank_right_r[search_bank_r][rd_idx_s[l][ADDR_W-1:0]];
      end else begin
        lane_right_s[l] = '0;
      end
    end
  end

  census_cost_lane #(
    .CENSUS_W (CENSUS_W),
    .LANES    (LANES),
    .COST_W   (COST_W)
  ) u_lane (
    .rclk  (rclk),
    .reset (reset),
    .left  (lane_left_s),
    .right (lane_right_s),
    .cost  (lane_cost_s)
  );

  // Strict less-than in ascending d keeps the smallest disparity on ties
  always_comb begin
    cand_cost_s = best_cost_r;
    cand_disp_s = best_disp_r;
    for (int l = 0; l < LANES; l++) begin
      cand_d_s[l] = IDX_W'(cost_grp_r) * IDX_W'(LANES) + IDX_W'(l);
      if ((cand_d_s[l] <= IDX_W'(DISP_MAX)) &&
          (IDX_W'(x_r) + cand_d_s[l] <= IDX_W'(bank_last_r[search_bank_r])) &&
          (lane_cost_s[l] < cand_cost_s)) begin
        cand_cost_s = lane_cost_s[l];
        cand_disp_s = DISP_W'(cand_d_s[l]);
      end else begin
        cand_cost_s = cand_cost_s;
        cand_disp_s = cand_disp_s;
      end
    end
    lowconf_s = (cand_cost_s > COST_W'(COST_THRESH));
  end

`ifdef CENSUS_FALLBACK_EN
  logic [DISP_W-1:0] prev_disp_r;
  assign emit_disp_s = lowconf_s ? prev_disp_r : cand_disp_s;
`else
  assign emit_disp_s = cand_disp_s;
`endif

  // Bank bookkeeping, search FSM and registered result outputs
  always_ff @(posedge rclk) begin
    if (reset) begin
      bank_full_r    <= 2'b00;
      bank_last_r[0] <= '0;
      bank_last_r[1] <= '0;
      fill_bank_r    <= 1'b0;
      fill_idx_r     <= '0;
      search_bank_r  <= 1'b0;
      state_r        <= ST_IDLE;
      x_r            <= '0;
      cost_grp_r     <= '0;
      best_cost_r    <= '1;
      best_disp_r    <= '0;
      out_valid      <= 1'b0;
      out_last       <= 1'b0;
      out_disp       <= '0;
      out_cost       <= '0;
      out_lowconf    <= 1'b0;
      err_len        <= 1'b0;
`ifdef CENSUS_FALLBACK_EN
      prev_disp_r    <= '0;
`endif
    end else begin
      err_len <= overlen_s;
      if (close_s) begin
        bank_full_r[fill_bank_r] <= 1'b1;
        bank_last_r[fill_bank_r] <= fill_idx_r;
        fill_bank_r              <= ~fill_bank_r;
        fill_idx_r               <= '0;
      end else if (beat_s) begin
        fill_idx_r <= fill_idx_r + ADDR_W'(1);
      end
      case (state_r)
        ST_IDLE: begin
          if (bank_full_r[search_bank_r]) begin
            x_r     <= '0;
            state_r <= ST_READ;
`ifdef CENSUS_FALLBACK_EN
            prev_disp_r <= '0;
`endif
          end
        end
        ST_READ: begin
          cost_grp_r  <= '0;
          best_cost_r <= '1;
          best_disp_r <= '0;
          state_r     <= ST_SEARCH;
        end
        ST_SEARCH: begin
          best_cost_r <= cand_cost_s;
          best_disp_r <= cand_disp_s;
          cost_grp_r  <= cost_grp_r + GRP_W'(1);
          if (cost_grp_r == GRP_W'(NGRP - 1)) begin
            out_valid   <= 1'b1;
            out_last    <= last_px_s;
            out_disp    <= emit_disp_s;
            out_cost    <= cand_cost_s;
            out_lowconf <= lowconf_s;
            state_r     <= ST_EMIT;
`ifdef CENSUS_FALLBACK_EN
            if (!lowconf_s) begin
              prev_disp_r <= cand_disp_s;
            end
`endif
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_px_s) begin
              bank_full_r[search_bank_r] <= 1'b0;
              search_bank_r              <= ~search_bank_r;
              state_r                    <= ST_IDLE;
            end else begin
              x_r     <= x_r + ADDR_W'(1);
              state_r <= ST_READ;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
